demux_1x16: RTL and testbench



---
 rtl/demux_1x16.sv | 25 ++
 tb/tb_demux_1x16.sv | 100 ++++++++++
 2 files changed

// File: rtl/demux_1x16.sv
// demux_1x16: registered 1-to-16 demultiplexer; the selected channel carries in, every other channel is zero
module demux_1x16 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in,
  input  logic [3:0]            sel,
  output logic [16*DATA_W-1:0]  y
);
  logic [15:0]          onehot;
  logic [16*DATA_W-1:0] y_d, y_q;
  // decode sel to one-hot and gate the data onto the chosen channel only
  always_comb begin
    onehot = 16'd1 << sel;
    y_d = '0;
    for (int k = 0; k < 16; k++) y_d[k*DATA_W +: DATA_W] = in & {DATA_W{onehot[k]}};
  end
  // output register loads every edge, clears asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else y_q <= y_d;
  end
  assign y = y_q;
endmodule

// File: tb/tb_demux_1x16.sv
// tb_demux_1x16: directed scoreboard bench for 1-bit and 4-bit wide demux instances
module tb_demux_1x16;
  typedef struct {
    string       tag;
    logic [15:0] e1;
    logic [63:0] e4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in1 = 1'b0;
  logic [3:0]  in4 = 4'h0;
  logic [3:0]  sel = 4'h0;
  logic [15:0] y1;
  logic [63:0] y4;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  demux_1x16 #(.DATA_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .y(y1));
  demux_1x16 #(.DATA_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .in(in4), .sel(sel), .y(y4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] e1, input logic [63:0] e4);
    checks++;
    assert (y1 === e1) else begin
      errors++;
      $error("FAIL %s y1 observed=%h expected=%h", tag, y1, e1);
    end
    checks++;
    assert (y4 === e4) else begin
      errors++;
      $error("FAIL %s y4 observed=%h expected=%h", tag, y4, e4);
    end
  endtask

  task automatic step(input string tag, input logic i, input logic [3:0] s, input logic [3:0] i4);
    exp_t e;
    in1 = i;
    in4 = i4;
    sel = s;
    q.push_back('{tag, i ? (16'h0001 << s) : 16'h0000, {60'd0, i4} << (4 * s)});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk(e.tag, e.e1, e.e4);
    checks++;
    assert ($countones(y1) === int'(i)) else begin
      errors++;
      $error("FAIL %s onehot observed=%0d expected=%0d", tag, $countones(y1), int'(i));
    end
  endtask

  initial begin
    in1 = 1'b1;
    in4 = 4'h7;
    sel = 4'd5;
    #1;
    chk("reset_t0", 16'h0000, 64'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 16'h0000, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    step("release", 1'b1, 4'd5, 4'h7);
    step("zero_in", 1'b0, 4'd10, 4'h0);
    for (int i = 0; i < 16; i++) step($sformatf("sweep%0d", i), 1'b1, 4'(i), 4'($urandom_range(15)));
    step("tog1", 1'b1, 4'd3, 4'h1);
    step("tog0", 1'b0, 4'd3, 4'h0);
    step("tog1b", 1'b1, 4'd3, 4'hF);
    #2;
    sel = 4'd9;
    in1 = 1'b0;
    #3;
    chk("between_edges", 16'h0008, 64'h0000_0000_0000_F000);
    step("d4_a", 1'b1, 4'd2, 4'hA);
    step("mid_pre", 1'b1, 4'd12, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async", 16'h0000, 64'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_hold", 16'h0000, 64'h0);
    step("mid_post", 1'b1, 4'd12, 4'h5);
    step("b2b_a", 1'b1, 4'd15, 4'h3);
    step("b2b_b", 1'b1, 4'd0, 4'h9);
    if (q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard leftover observed=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
